// File: rtl/stopwatch_bcd.sv
// BCD stopwatch MM:SS.CC. It is advanced by the rising edges of a slow tick
// input that is asynchronous to clkin. It has start/stop, clear and lap-hold
// controls, and drives a 6-digit BCD display bus.
module stopwatch_bcd #(
   parameter int SYNC_STAGES = 2,   // tick_in synchroniser depth, >= 2
   parameter int MIN_LIMIT   = 59   // highest minutes value before wrap, 0..99
) (
   input  logic        clkin,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [23:0] disp_bcd,
   output logic        running,
   output logic        held,
   output logic        wrap
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   // Field order matches the display bus, so the struct maps straight onto disp_bcd.
   typedef struct packed {
      logic [3:0] m_hi;
      logic [3:0] m_lo;
      logic [3:0] s_hi;
      logic [3:0] s_lo;
      logic [3:0] cs_hi;
      logic [3:0] cs_lo;
   } bcd_t;

   localparam logic [3:0] MIN_HI = 4'(MIN_LIMIT / 10);
   localparam logic [3:0] MIN_LO = 4'(MIN_LIMIT % 10);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   tick;
   state_t                 state_q, state_d;
   bcd_t                   cnt_q, cnt_d, cnt_inc, lap_q, lap_d;
   logic                   held_q, held_d, wrap_q, wrap_d, inc_wrap;

   // The tick is the first cycle in which the synchronised level is seen high.
   assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Synchroniser chain and edge-detect register for the asynchronous tick input.
   // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Compute count+1 as a BCD ripple carry, and flag the MIN_LIMIT:59.99 rollover.
   // NOTE: every output of this block is assigned first, so no path can infer a latch.
   always_comb begin
      cnt_inc  = cnt_q;
      inc_wrap = 1'b0;
      if (cnt_q.cs_lo != 4'd9) begin
         cnt_inc.cs_lo = cnt_q.cs_lo + 4'd1;
      end else begin
         cnt_inc.cs_lo = 4'd0;
         if (cnt_q.cs_hi != 4'd9) begin
            cnt_inc.cs_hi = cnt_q.cs_hi + 4'd1;
         end else begin
            cnt_inc.cs_hi = 4'd0;
            if (cnt_q.s_lo != 4'd9) begin
               cnt_inc.s_lo = cnt_q.s_lo + 4'd1;
            end else begin
               cnt_inc.s_lo = 4'd0;
               if (cnt_q.s_hi != 4'd5) begin
                  cnt_inc.s_hi = cnt_q.s_hi + 4'd1;
               end else begin
                  cnt_inc.s_hi = 4'd0;
                  if (cnt_q.m_hi == MIN_HI && cnt_q.m_lo == MIN_LO) begin
                     cnt_inc.m_hi = 4'd0;
                     cnt_inc.m_lo = 4'd0;
                     inc_wrap     = 1'b1;
                  end else if (cnt_q.m_lo != 4'd9) begin
                     cnt_inc.m_lo = cnt_q.m_lo + 4'd1;
                  end else begin
                     cnt_inc.m_lo = 4'd0;
                     cnt_inc.m_hi = cnt_q.m_hi + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Next state and data. Clear wins. The tick and the lap capture use the state
   // and count from before this edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lap_d   = lap_q;
      held_d  = held_q;
      wrap_d  = 1'b0;
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         held_d  = 1'b0;
      end else begin
         if (state_q == RUN && tick) begin
            cnt_d  = cnt_inc;
            wrap_d = inc_wrap;
         end
         if (lap) begin
            if (held_q && state_q != IDLE) begin
               held_d = 1'b0;
            end else if (!held_q && state_q == RUN) begin
               lap_d  = cnt_q;
               held_d = 1'b1;
            end
         end
         if (start_stop) begin
            case (state_q)
               IDLE:    state_d = RUN;
               RUN:     state_d = PAUSE;
               PAUSE:   state_d = RUN;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // State, count, lap and flag registers; reset takes effect without a clock.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lap_q   <= '0;
         held_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lap_q   <= lap_d;
         held_q  <= held_d;
         wrap_q  <= wrap_d;
      end
   end

   assign disp_bcd = held_q ? lap_q : cnt_q;
   assign running  = (state_q == RUN);
   assign held     = held_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd. Instance u_a uses the default minute limit
// (59). Instance u_b uses MIN_LIMIT=0 so that the rollover can be reached.
// Both instances share all inputs. Inputs are driven and outputs sampled on the
// falling edge of clkin.
module tb_stopwatch_bcd;

   localparam int SS = 2;

   logic        clkin = 1'b0;
   logic        rst = 1'b1;
   logic        tick_in = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        lap = 1'b0;
   logic [23:0] disp_a, disp_b;
   logic        running_a, running_b, held_a, held_b, wrap_a, wrap_b;

   int n_cmp = 0;
   int n_err = 0;

   stopwatch_bcd #(.SYNC_STAGES(SS), .MIN_LIMIT(59)) u_a (
      .clkin(clkin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
      .clear(clear), .lap(lap), .disp_bcd(disp_a), .running(running_a),
      .held(held_a), .wrap(wrap_a)
   );

   stopwatch_bcd #(.SYNC_STAGES(SS), .MIN_LIMIT(0)) u_b (
      .clkin(clkin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
      .clear(clear), .lap(lap), .disp_bcd(disp_b), .running(running_b),
      .held(held_b), .wrap(wrap_b)
   );

   always #5 clkin = ~clkin;

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // n tick_in periods of hi/lo clkin cycles; entered and left on a falling edge.
   task automatic tick_n(input int n, input int hi, input int lo);
      for (int k = 0; k < n; k++) begin
         tick_in = 1'b1;
         repeat (hi) @(negedge clkin);
         tick_in = 1'b0;
         repeat (lo) @(negedge clkin);
      end
   endtask

   // One-cycle control pulse.
   task automatic pulse(input logic s, input logic c, input logic l);
      start_stop = s;
      clear      = c;
      lap        = l;
      @(negedge clkin);
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
   endtask

   // A tick whose detected edge lands on the same clkin edge as the control pulse.
   task automatic tick_with(input logic s, input logic c, input logic l);
      tick_in = 1'b1;
      repeat (SS) @(negedge clkin);
      pulse(s, c, l);
      tick_in = 1'b0;
      repeat (3) @(negedge clkin);
   endtask

   initial begin
      // ---- reset state
      repeat (3) @(negedge clkin);
      check("rst_disp", disp_a, 24'h0);
      check("rst_running", {23'd0, running_a}, 24'd0);
      check("rst_held", {23'd0, held_a}, 24'd0);
      check("rst_wrap", {23'd0, wrap_b}, 24'd0);
      rst = 1'b0;
      @(negedge clkin);

      // ---- 1: start, first-tick latency, 100 ticks
      pulse(1'b1, 1'b0, 1'b0);
      check("t1_running", {23'd0, running_a}, 24'd1);
      tick_in = 1'b1;
      repeat (SS) @(negedge clkin);
      check("t1_lat_before", disp_a, 24'h000000);
      @(negedge clkin);
      check("t1_lat_at", disp_a, 24'h000001);
      repeat (1000 - SS - 1) @(negedge clkin);
      tick_in = 1'b0;
      repeat (1000) @(negedge clkin);
      tick_n(1, 1000, 1000);
      tick_n(98, 2, 2);
      check("t1_100", disp_a, 24'h000100);

      // ---- 2: a long high level counts once; pause ignores ticks
      tick_in = 1'b1;
      repeat (5000) @(negedge clkin);
      tick_in = 1'b0;
      repeat (4) @(negedge clkin);
      check("t2_long_high", disp_a, 24'h000101);
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(50, 2, 2);
      check("t2_pause_cnt", disp_a, 24'h000101);
      check("t2_pause_run", {23'd0, running_a}, 24'd0);
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(1, 2, 2);
      check("t2_resume", disp_a, 24'h000102);
      tick_with(1'b1, 1'b0, 1'b0);
      check("t2_tick_ss_cnt", disp_a, 24'h000103);
      check("t2_tick_ss_run", {23'd0, running_a}, 24'd0);

      // ---- 3: carries and rollover with MIN_LIMIT=0 (u_b)
      pulse(1'b0, 1'b1, 1'b0);
      check("t3_clear", disp_b, 24'h0);
      check("t3_clear_run", {23'd0, running_b}, 24'd0);
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(999, 2, 2);
      check("t3_0999", disp_b, 24'h000999);
      tick_n(1, 2, 2);
      check("t3_1000", disp_b, 24'h001000);
      tick_n(4999, 2, 2);
      check("t3_5999", disp_b, 24'h005999);
      tick_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clkin);
         check($sformatf("t3_wrap_c%0d", i), {23'd0, wrap_b}, (i == SS + 1) ? 24'd1 : 24'd0);
         if (i == SS + 1) check("t3_wrap_zero", disp_b, 24'h0);
      end
      tick_in = 1'b0;
      repeat (2) @(negedge clkin);
      check("t3_wrap_run", {23'd0, running_b}, 24'd1);
      check("t3_a_minute", disp_a, 24'h010000);

      // ---- 4: lap hold, with the capture coinciding with a tick
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check("t4_idle_lap", {23'd0, held_a}, 24'd0);
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(325, 2, 2);
      check("t4_0325", disp_a, 24'h000325);
      tick_with(1'b0, 1'b0, 1'b1);
      check("t4_held", {23'd0, held_a}, 24'd1);
      check("t4_capture", disp_a, 24'h000325);
      tick_n(199, 2, 2);
      check("t4_frozen", disp_a, 24'h000325);
      check("t4_still_held", {23'd0, held_a}, 24'd1);
      pulse(1'b0, 1'b0, 1'b1);
      check("t4_release", disp_a, 24'h000525);
      check("t4_unheld", {23'd0, held_a}, 24'd0);

      // ---- 5: clear + start_stop + tick in one cycle while held in RUN
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(700, 2, 2);
      check("t5_0700", disp_a, 24'h000700);
      pulse(1'b0, 1'b0, 1'b1);
      tick_with(1'b1, 1'b1, 1'b0);
      check("t5_disp", disp_a, 24'h0);
      check("t5_held", {23'd0, held_a}, 24'd0);
      check("t5_running", {23'd0, running_a}, 24'd0);
      tick_n(5, 2, 2);
      check("t5_ignored", disp_a, 24'h0);

      // ---- 6: asynchronous reset mid-run
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(4217, 2, 2);
      check("t6_4217", disp_a, 24'h004217);
      pulse(1'b0, 1'b0, 1'b1);
      check("t6_held_pre", {23'd0, held_a}, 24'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_disp", disp_a, 24'h0);
      check("t6_rst_run", {23'd0, running_a}, 24'd0);
      check("t6_rst_held", {23'd0, held_a}, 24'd0);
      repeat (2) @(negedge clkin);
      rst = 1'b0;
      @(negedge clkin);
      tick_n(3, 2, 2);
      check("t6_idle_disp", disp_a, 24'h0);
      check("t6_idle_run", {23'd0, running_a}, 24'd0);
      pulse(1'b1, 1'b0, 1'b0);
      tick_n(1, 2, 2);
      check("t6_restart", disp_a, 24'h000001);
      check("t6_restart_run", {23'd0, running_a}, 24'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Downstream consumer of the divided clock from the clock generator. That slow square wave (e.g. 100 Hz) enters here as a plain data input, `tick_in`.
- The block synchronises `tick_in` into the system clock domain and detects its rising edges.
- Each rising edge advances a BCD stopwatch, MM:SS.CC, with start/stop, clear and lap-hold control.
- Output is a 6-digit BCD bus for the seven-segment scanning stage.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `tick_in` synchroniser chain; legal values are 2 or more.
- MIN_LIMIT, 59, highest minutes value before wrap; legal range 0..99.

Ports:
- clkin  input  1  system clock (100 MHz); the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- tick_in  input  1  divided clock from the clock generator; asynchronous to the logic, so it is synchronised here.
- start_stop  input  1  one-cycle pulse; toggles between running and paused.
- clear  input  1  one-cycle pulse; zeroes the count and returns to IDLE.
- lap  input  1  one-cycle pulse; freezes or releases the displayed value.
- disp_bcd  output  24  {m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo}, 4 bits per digit.
- running  output  1  high while in state RUN.
- held  output  1  high while the display is frozen.
- wrap  output  1  one-cycle pulse when the count rolls over from MIN_LIMIT:59.99.

Behaviour:
- Interface (already decided): one clock, `clkin`; reset `rst` is asynchronous and active-high.
- Reset values: all registers clear, including the synchroniser chain and the edge-detect register; state is IDLE; disp_bcd=0, running=0, held=0, wrap=0.
- Reset mid-operation: same values, applied immediately, with no clock edge needed.
- Synchroniser: `tick_in` passes through SYNC_STAGES flops. `prev` holds the last synchroniser output.
- Tick detection: tick = sync_out & ~prev. Exactly one tick per rising edge of `tick_in`, however long `tick_in` stays high.
- Latency: `tick_in` first sampled high at edge E0; the count register changes at edge E(SYNC_STAGES).
- States and transitions:
  - IDLE: count held at 0, ticks ignored. start_stop moves to RUN.
  - RUN: each tick increments the count. start_stop moves to PAUSE.
  - PAUSE: ticks ignored, count retained. start_stop moves to RUN.
  - clear from any state moves to IDLE and sets count=0 and held=0.
- Priority within a single cycle:
  - clear beats everything else.
  - A tick coinciding with start_stop is applied according to the state before the transition, so RUN+tick+start_stop increments and then pauses.
  - A tick coinciding with lap: the lap capture takes the pre-increment count.
- Counter digits and carries:
  - cs_lo counts 0..9 and carries into cs_hi (0..9).
  - cs_hi carries into s_lo (0..9), which carries into s_hi (0..5).
  - s_hi carries into minutes, held as two BCD digits counting 0..MIN_LIMIT.
  - Each digit stays within its legal BCD range at all times.
- Wrap: a tick at MIN_LIMIT:59.99 sets every digit to 0 and pulses wrap high for exactly one cycle, coinciding with the zeroed count. State stays RUN.
- Lap hold:
  - In RUN, a lap pulse with held=0 copies the count into lap_reg and sets held=1.
  - In RUN or PAUSE, a lap pulse with held=1 clears held.
  - In IDLE, lap is ignored.
- Display: disp_bcd = held ? lap_reg : count. Both sources are registered, so disp_bcd shows no extra latency relative to the count.
- Outputs: running = (state==RUN). All outputs come from registers or a mux of registers and are glitch-free with respect to `tick_in`.

Test Plan:
1. Reset released, start_stop pulse, then 100 `tick_in` periods (each 1000 clkin cycles high and 1000 low) -> disp_bcd=24'h000100, running=1. Check that the first increment lands at the SYNC_STAGES-th clkin edge after `tick_in` rises.
2. Hold `tick_in` high for 5000 cycles while in RUN -> count increases by exactly 1. Then pulse start_stop and apply 50 ticks -> count unchanged and running=0. Pulse start_stop again -> counting resumes from the held value.
3. Set MIN_LIMIT=0 and run to 00:59.99, then apply one tick -> disp_bcd=0, wrap high for exactly 1 cycle, running=1. At 00:09.99 plus one tick -> 24'h001000.
4. At 00:03.25 pulse lap, then apply 200 ticks -> disp_bcd stays 24'h000325 and held=1. Pulse lap -> disp_bcd=24'h000525 and held=0.
5. clear, start_stop and a tick all in the same cycle while in RUN at 00:07.00 -> state IDLE, disp_bcd=0, held=0. Ticks afterwards are ignored.
6. Assert rst asynchronously (between clkin edges) at 00:42.17 during RUN -> disp_bcd=0, running=0, held=0 immediately. After release the block stays in IDLE until a start_stop pulse.
